fpu_ret_collect: RTL and testbench

FPU_RET_COLLECT -- requirements
Module: fpu_ret_collect

---
 rtl/fpu_ret_collect_if.sv | 16 +
 rtl/fpu_ret_collect.sv | 107 ++++++++++
 tb/tb_fpu_ret_collect.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_ret_collect_if.sv
// Completion bundle between the three FP return ports, the collector and its consumer.
interface fpu_ret_collect_if;
  logic [13:0] u1_ret, u3_ret, u5_ret;
  logic        u1_ret_en, u3_ret_en, u5_ret_en;
  logic [13:0] out_ret;
  logic        out_valid, out_ready, out_trap;

  modport master (
    output u1_ret, u3_ret, u5_ret, u1_ret_en, u3_ret_en, u5_ret_en, out_ready,
    input  out_ret, out_valid, out_trap
  );
  modport slave (
    input  u1_ret, u3_ret, u5_ret, u1_ret_en, u3_ret_en, u5_ret_en, out_ready,
    output out_ret, out_valid, out_trap
  );
endinterface

// File: rtl/fpu_ret_collect.sv
// Collects up to three FP completions per cycle into an in-order FIFO and
// tracks sticky exception flags, overflow and trap status of the head entry.
module fpu_ret_lane #(
  parameter int CW = 4
) (
  input  logic          en,
  input  logic [1:0]    prior,
  input  logic [CW-1:0] room,
  output logic          acc
);
  // A lane fits when the enabled lanes ahead of it have not used up the room.
  assign acc = en && (CW'(prior) < room);
endmodule

module fpu_ret_collect #(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             fpcsr,
  fpu_ret_collect_if.slave        ret,
  input  logic                    flags_clr,
  output logic [5:0]              flags_sticky,
  output logic [$clog2(DEPTH):0]  free_cnt,
  output logic                    overflow
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int LANES = 3;

  logic [13:0]                 mem [DEPTH];
  logic [PW-1:0]               rd_ptr, wr_ptr;
  logic [CW-1:0]               count, count_next, room, n_acc;
  logic [LANES-1:0][13:0]      lane_word;
  logic [LANES-1:0]            lane_en, lane_acc;
  logic [LANES-1:0][1:0]       lane_pos;
  logic [5:0]                  flag_or;
  logic                        pop, drop;
  logic                        unused_fpcsr;

  assign unused_fpcsr = ^{fpcsr[31:13], fpcsr[6:0]};

  assign lane_word = {ret.u5_ret, ret.u3_ret, ret.u1_ret};
  assign lane_en   = {ret.u5_ret_en, ret.u3_ret_en, ret.u1_ret_en};

  assign ret.out_valid = (count != '0);
  assign ret.out_ret   = ret.out_valid ? mem[rd_ptr] : '0;
  assign ret.out_trap  = ret.out_valid & |(ret.out_ret[5:0] & ~fpcsr[12:7]);

  assign pop  = ret.out_valid & ret.out_ready;
  // A slot freed by this cycle's pop is usable by this cycle's pushes.
  assign room = CW'(DEPTH) - count + CW'(pop);

  always_comb begin
    lane_pos = '0;
    for (int i = 1; i < LANES; i++)
      lane_pos[i] = lane_pos[i-1] + 2'(lane_en[i-1]);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fpu_ret_lane #(.CW(CW)) u_lane (
      .en    (lane_en[i]),
      .prior (lane_pos[i]),
      .room  (room),
      .acc   (lane_acc[i])
    );
  end

  always_comb begin
    n_acc   = '0;
    flag_or = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_acc[i]) begin
        n_acc   = n_acc + CW'(1);
        flag_or = flag_or | lane_word[i][5:0];
      end
    end
    drop       = |(lane_en & ~lane_acc);
    count_next = count + n_acc - CW'(pop);
  end

  // Accepted lanes are packed contiguously from wr_ptr, so lane_pos is the slot offset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++)
        if (lane_acc[i]) mem[wr_ptr + PW'(lane_pos[i])] <= lane_word[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      free_cnt     <= CW'(DEPTH);
      flags_sticky <= '0;
      overflow     <= 1'b0;
    end else begin
      rd_ptr       <= rd_ptr + PW'(pop);
      wr_ptr       <= wr_ptr + n_acc[PW-1:0];
      count        <= count_next;
      free_cnt     <= CW'(DEPTH) - count_next;
      flags_sticky <= (flags_clr ? 6'h00 : flags_sticky) | flag_or;
      overflow     <= overflow | drop;
    end
  end
endmodule

// File: tb/tb_fpu_ret_collect.sv
// Scenario and randomized checks of fpu_ret_collect against a queue-based model.
module tb_fpu_ret_collect;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fpcsr = '0;
  logic        flags_clr = 1'b0;
  logic [5:0]  flags_sticky;
  logic [3:0]  free_cnt;
  logic        overflow;

  fpu_ret_collect_if rif ();

  fpu_ret_collect #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .fpcsr        (fpcsr),
    .ret          (rif.slave),
    .flags_clr    (flags_clr),
    .flags_sticky (flags_sticky),
    .free_cnt     (free_cnt),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [13:0] q[$];
  logic [5:0]  m_flags = '0;
  logic        m_ovf   = 1'b0;

  // Drive one cycle of inputs, advance the model across the edge, return #1 after it.
  task automatic tick(input logic r, input logic [2:0] en, input logic [13:0] w1,
                      input logic [13:0] w3, input logic [13:0] w5,
                      input logic rdy, input logic clr);
    logic [13:0] w [3];
    logic [5:0]  f;
    int          cap, acc;
    logic        do_pop;
    rst = r; flags_clr = clr; rif.out_ready = rdy;
    rif.u1_ret_en = en[0]; rif.u3_ret_en = en[1]; rif.u5_ret_en = en[2];
    rif.u1_ret = w1; rif.u3_ret = w3; rif.u5_ret = w5;
    w[0] = w1; w[1] = w3; w[2] = w5;
    @(posedge clk);
    if (r) begin
      q.delete(); m_flags = '0; m_ovf = 1'b0;
    end else begin
      do_pop = (q.size() > 0) && rdy;
      cap    = DEPTH - q.size() + int'(do_pop);
      f      = clr ? 6'h00 : m_flags;
      if (do_pop) void'(q.pop_front());
      acc = 0;
      for (int k = 0; k < 3; k++) begin
        if (en[k]) begin
          if (acc < cap) begin
            q.push_back(w[k]); f = f | w[k][5:0]; acc++;
          end else m_ovf = 1'b1;
        end
      end
      m_flags = f;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 3'b000, '0, '0, '0, 1'b0, 1'b0);
    checks++; if (rif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rif.out_valid); end
    checks++; if (rif.out_ret !== 14'h0) begin errors++; $display("FAIL reset_ret got=%h exp=0", rif.out_ret); end
    checks++; if (rif.out_trap !== 1'b0) begin errors++; $display("FAIL reset_trap got=%b exp=0", rif.out_trap); end
    checks++; if (flags_sticky !== 6'h0) begin errors++; $display("FAIL reset_flags got=%h exp=0", flags_sticky); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (free_cnt !== 4'd8) begin errors++; $display("FAIL reset_free got=%0d exp=8", free_cnt); end
  endtask

  task automatic test_single();
    fpcsr = 32'h0; fpcsr[12:7] = 6'h3F;
    tick(1'b0, 3'b001, 14'h0141, '0, '0, 1'b0, 1'b0);
    checks++; if (rif.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", rif.out_valid); end
    checks++; if (rif.out_ret !== 14'h0141) begin errors++; $display("FAIL single_ret got=%h exp=0141", rif.out_ret); end
    checks++; if (rif.out_trap !== 1'b0) begin errors++; $display("FAIL single_trap got=%b exp=0", rif.out_trap); end
    checks++; if (flags_sticky !== 6'h01) begin errors++; $display("FAIL single_flags got=%h exp=01", flags_sticky); end
    checks++; if (free_cnt !== 4'd7) begin errors++; $display("FAIL single_free got=%0d exp=7", free_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_tag;
    tick(1'b1, 3'b000, '0, '0, '0, 1'b0, 1'b0);
    tick(1'b0, 3'b111, {8'd1, 6'h0}, {8'd2, 6'h0}, {8'd3, 6'h0}, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_tag = 8'(i + 1);
      checks++; if (rif.out_valid !== 1'b1 || rif.out_ret[13:6] !== exp_tag) begin
        errors++; $display("FAIL order_tag%0d got valid=%b tag=%0d exp tag=%0d", i, rif.out_valid, rif.out_ret[13:6], exp_tag);
      end
      tick(1'b0, 3'b000, '0, '0, '0, 1'b1, 1'b0);
    end
    checks++; if (rif.out_valid !== 1'b0) begin errors++; $display("FAIL order_empty got=%b exp=0", rif.out_valid); end
  endtask

  task automatic test_overflow();
    tick(1'b1, 3'b000, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b0, 3'b001, {8'(i), 6'h0}, '0, '0, 1'b0, 1'b0);
    checks++; if (free_cnt !== 4'd1) begin errors++; $display("FAIL ovf_pre_free got=%0d exp=1", free_cnt); end
    tick(1'b0, 3'b111, {8'd40, 6'h01}, {8'd41, 6'h02}, {8'd42, 6'h04}, 1'b0, 1'b0);
    checks++; if (free_cnt !== 4'd0) begin errors++; $display("FAIL ovf_free got=%0d exp=0", free_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (flags_sticky !== 6'h01) begin errors++; $display("FAIL ovf_flags got=%h exp=01", flags_sticky); end
    tick(1'b0, 3'b000, '0, '0, '0, 1'b1, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_keep got=%b exp=1", overflow); end
    tick(1'b1, 3'b000, '0, '0, '0, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset got=%b exp=0", overflow); end
  endtask

  task automatic test_full_pushpop();
    tick(1'b1, 3'b000, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 3'b001, {8'(i + 10), 6'h0}, '0, '0, 1'b0, 1'b0);
    tick(1'b0, 3'b001, {8'd99, 6'h0}, '0, '0, 1'b1, 1'b0);
    checks++; if (free_cnt !== 4'd0) begin errors++; $display("FAIL full_free got=%0d exp=0", free_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf got=%b exp=0", overflow); end
    checks++; if (rif.out_ret !== {8'd11, 6'h0}) begin errors++; $display("FAIL full_head got=%h exp=%h", rif.out_ret, {8'd11, 6'h0}); end
    for (int i = 0; i < 7; i++) tick(1'b0, 3'b000, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (rif.out_ret !== {8'd99, 6'h0}) begin errors++; $display("FAIL full_wrap got=%h exp=%h", rif.out_ret, {8'd99, 6'h0}); end
  endtask

  task automatic test_clr_set();
    tick(1'b1, 3'b000, '0, '0, '0, 1'b0, 1'b0);
    tick(1'b0, 3'b001, {8'd1, 6'h01}, '0, '0, 1'b1, 1'b0);
    tick(1'b0, 3'b010, '0, {8'd2, 6'h04}, '0, 1'b1, 1'b1);
    checks++; if (flags_sticky !== 6'h04) begin errors++; $display("FAIL clr_set got=%h exp=04", flags_sticky); end
    tick(1'b0, 3'b000, '0, '0, '0, 1'b1, 1'b1);
    checks++; if (flags_sticky !== 6'h00) begin errors++; $display("FAIL clr_only got=%h exp=00", flags_sticky); end
  endtask

  task automatic test_trap();
    tick(1'b1, 3'b000, '0, '0, '0, 1'b0, 1'b0);
    fpcsr[12:7] = 6'h3B;
    tick(1'b0, 3'b100, '0, '0, {8'd7, 6'h04}, 1'b0, 1'b0);
    checks++; if (rif.out_trap !== 1'b1) begin errors++; $display("FAIL trap_unmasked got=%b exp=1", rif.out_trap); end
    fpcsr[12:7] = 6'h3F; #1;
    checks++; if (rif.out_trap !== 1'b0) begin errors++; $display("FAIL trap_masked got=%b exp=0", rif.out_trap); end
    fpcsr[12:7] = 6'h3B;
    tick(1'b1, 3'b111, 14'h3FFF, 14'h3FFF, 14'h3FFF, 1'b0, 1'b0);
    checks++; if (rif.out_valid !== 1'b0 || rif.out_trap !== 1'b0) begin
      errors++; $display("FAIL trap_reset got valid=%b trap=%b exp 0/0", rif.out_valid, rif.out_trap);
    end
    checks++; if (free_cnt !== 4'd8 || overflow !== 1'b0) begin
      errors++; $display("FAIL trap_reset_state got free=%0d ovf=%b exp 8/0", free_cnt, overflow);
    end
  endtask

  task automatic test_random();
    logic [13:0] exp_ret;
    logic        exp_trap;
    tick(1'b1, 3'b000, '0, '0, '0, 1'b0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      fpcsr = $urandom;
      tick(($urandom_range(0, 49) == 0), 3'($urandom), 14'($urandom), 14'($urandom), 14'($urandom),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0));
      exp_ret  = (q.size() > 0) ? q[0] : 14'h0;
      exp_trap = (q.size() > 0) && |(exp_ret[5:0] & ~fpcsr[12:7]);
      checks++; if (rif.out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, rif.out_valid, q.size() > 0); end
      checks++; if (rif.out_ret !== exp_ret) begin errors++; $display("FAIL rnd_ret cyc=%0d got=%h exp=%h", n, rif.out_ret, exp_ret); end
      checks++; if (rif.out_trap !== exp_trap) begin errors++; $display("FAIL rnd_trap cyc=%0d got=%b exp=%b", n, rif.out_trap, exp_trap); end
      checks++; if (flags_sticky !== m_flags) begin errors++; $display("FAIL rnd_flags cyc=%0d got=%h exp=%h", n, flags_sticky, m_flags); end
      checks++; if (free_cnt !== 4'(DEPTH - q.size())) begin errors++; $display("FAIL rnd_free cyc=%0d got=%0d exp=%0d", n, free_cnt, DEPTH - q.size()); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", n, overflow, m_ovf); end
    end
  endtask

  initial begin
    rif.u1_ret = '0; rif.u3_ret = '0; rif.u5_ret = '0;
    rif.u1_ret_en = 1'b0; rif.u3_ret_en = 1'b0; rif.u5_ret_en = 1'b0;
    rif.out_ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pushpop();
    test_clr_set();
    test_trap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
